// File: rtl/inst_decode_queue.sv
`default_nettype none
// ============================================================================
// inst_decode_queue : fetch queue with combinational MIPS32 decode and dual issue
// Revision 1.0
// ============================================================================
module inst_decode_queue #(
    parameter int DEPTH   = 8,
    parameter int ISSUE_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             in_valid,
    input  logic [63:0]            in_instr,
    input  logic [63:0]            in_pc,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic                   out_ready,
    output logic [ISSUE_W-1:0]     out_valid,
    output logic [32*ISSUE_W-1:0]  out_instr,
    output logic [32*ISSUE_W-1:0]  out_pc,
    output logic [24*ISSUE_W-1:0]  out_ctrl,
    output logic [$clog2(DEPTH):0] count
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0] CNT_LIM = (AW+1)'(DEPTH - 2);

    localparam logic [3:0] ALU_ADD  = 4'd0,  ALU_SUB   = 4'd1,  ALU_AND  = 4'd2,  ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4,  ALU_NOR   = 4'd5,  ALU_SLT  = 4'd6,  ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8,  ALU_SRL   = 4'd9,  ALU_SRA  = 4'd10, ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_MULT = 4'd12, ALU_MULTU = 4'd13, ALU_DIV  = 4'd14, ALU_DIVU = 4'd15;

    function automatic logic [23:0] decode(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [5:0] fn);
        logic [23:0] c;
        c = '0;
        case (op)
            6'h00: begin
                c[0] = 1'b1;  // most SPECIAL functs write rd; the rest clear it
                case (fn)
                    6'h00, 6'h04: c[10:7] = ALU_SLL;
                    6'h02, 6'h06: c[10:7] = ALU_SRL;
                    6'h03, 6'h07: c[10:7] = ALU_SRA;
                    6'h08:        begin c[0] = 1'b0; c[22] = 1'b1; end
                    6'h09:        c[22] = 1'b1;
                    6'h0c:        begin c[0] = 1'b0; c[16] = 1'b1; end
                    6'h0d:        begin c[0] = 1'b0; c[15] = 1'b1; end
                    6'h10, 6'h12: c[20] = 1'b1;
                    6'h11, 6'h13: c[0] = 1'b0;
                    6'h18:        begin c[0] = 1'b0; c[10:7] = ALU_MULT;  end
                    6'h19:        begin c[0] = 1'b0; c[10:7] = ALU_MULTU; end
                    6'h1a:        begin c[0] = 1'b0; c[10:7] = ALU_DIV;   end
                    6'h1b:        begin c[0] = 1'b0; c[10:7] = ALU_DIVU;  end
                    6'h20, 6'h21: c[10:7] = ALU_ADD;
                    6'h22, 6'h23: c[10:7] = ALU_SUB;
                    6'h24:        c[10:7] = ALU_AND;
                    6'h25:        c[10:7] = ALU_OR;
                    6'h26:        c[10:7] = ALU_XOR;
                    6'h27:        c[10:7] = ALU_NOR;
                    6'h2a:        c[10:7] = ALU_SLT;
                    6'h2b:        c[10:7] = ALU_SLTU;
                    default:      begin c[0] = 1'b0; c[14] = 1'b1; end
                endcase
            end
            6'h01: begin
                c[13:11] = 3'b101;
                case (rt)
                    5'h00:   c[23] = 1'b1;
                    5'h01:   begin c[23] = 1'b1; c[13:11] = 3'b110; end
                    5'h10:   begin c[23] = 1'b1; c[0] = 1'b1; c[2:1] = 2'b10; end
                    5'h11:   begin c[23] = 1'b1; c[0] = 1'b1; c[2:1] = 2'b10; c[13:11] = 3'b110; end
                    default: c[14] = 1'b1;
                endcase
            end
            6'h02: c[22] = 1'b1;
            6'h03: begin c[22] = 1'b1; c[0] = 1'b1; c[2:1] = 2'b10; end
            6'h04: begin c[23] = 1'b1; c[13:11] = 3'b001; c[10:7] = ALU_SUB; end
            6'h05: begin c[23] = 1'b1; c[13:11] = 3'b010; c[10:7] = ALU_SUB; end
            6'h06: begin c[23] = 1'b1; c[13:11] = 3'b011; end
            6'h07: begin c[23] = 1'b1; c[13:11] = 3'b100; end
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
                c[0] = 1'b1; c[2:1] = 2'b01; c[3] = 1'b1;
                c[21] = (op[5:2] == 4'b0010);
                case (op[2:0])
                    3'd0, 3'd1: c[10:7] = ALU_ADD;
                    3'd2:       c[10:7] = ALU_SLT;
                    3'd3:       c[10:7] = ALU_SLTU;
                    3'd4:       c[10:7] = ALU_AND;
                    3'd5:       c[10:7] = ALU_OR;
                    3'd6:       c[10:7] = ALU_XOR;
                    default:    c[10:7] = ALU_LUI;
                endcase
            end
            6'h10: begin
                case (rs)
                    5'h00:   begin c[0] = 1'b1; c[2:1] = 2'b01; c[19] = 1'b1; end
                    5'h04:   c[18] = 1'b1;
                    5'h10:   if (fn == 6'h18) c[17] = 1'b1; else c[14] = 1'b1;
                    default: c[14] = 1'b1;
                endcase
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                c[0] = 1'b1; c[2:1] = 2'b01; c[3] = 1'b1; c[4] = 1'b1; c[6] = 1'b1; c[21] = 1'b1;
                c[10:7] = ALU_ADD;
            end
            6'h28, 6'h29, 6'h2b: begin
                c[3] = 1'b1; c[5] = 1'b1; c[21] = 1'b1; c[10:7] = ALU_ADD;
            end
            default: c[14] = 1'b1;
        endcase
        return c;
    endfunction

    function automatic logic reads_rt(input logic [5:0] op, input logic [4:0] rs);
        return (op == 6'h00) || (op == 6'h04) || (op == 6'h05) ||
               (op[5:3] == 3'b101) || ((op == 6'h10) && (rs == 5'h04));
    endfunction

    function automatic logic [4:0] dest_reg(input logic [1:0] regdst, input logic [4:0] rt,
                                            input logic [4:0] rd);
        case (regdst)
            2'b00:   return rd;
            2'b01:   return rt;
            default: return 5'd31;
        endcase
    endfunction

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr1, rd_ptr1;
    logic [1:0]    push_n, pop_n;
    logic [31:0]   instr0, pc0;
    logic [23:0]   ctrl0;
    logic          has1;

    assign in_ready = (count <= CNT_LIM);
    assign push_n   = in_ready ? ({1'b0, in_valid[1]} + {1'b0, in_valid[0]}) : 2'd0;
    assign wr_ptr1  = wr_ptr + AW'(1);
    assign rd_ptr1  = rd_ptr + AW'(1);
    assign has1     = (count != '0) && !flush;

    always_comb begin
        instr0 = instr_mem[rd_ptr];
        pc0    = pc_mem[rd_ptr];
        ctrl0  = decode(instr0[31:26], instr0[25:21], instr0[20:16], instr0[5:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_n);
            rd_ptr <= rd_ptr + AW'(pop_n);
            count  <= count + (AW+1)'(push_n) - (AW+1)'(pop_n);
        end
    end

    // Storage is not reset; pointers and count alone define what is live.
    always_ff @(posedge clk) begin
        if (!flush && in_ready) begin
            if (in_valid[0]) begin
                instr_mem[wr_ptr] <= in_instr[31:0];
                pc_mem[wr_ptr]    <= in_pc[31:0];
            end
            if (in_valid[1]) begin
                instr_mem[wr_ptr1] <= in_instr[63:32];
                pc_mem[wr_ptr1]    <= in_pc[63:32];
            end
        end
    end

    generate
        if (ISSUE_W == 2) begin : g_dual
            logic [31:0] instr1, pc1;
            logic [23:0] ctrl1;
            logic [4:0]  dst0;
            logic        raw, pair_ok;

            always_comb begin
                instr1  = instr_mem[rd_ptr1];
                pc1     = pc_mem[rd_ptr1];
                ctrl1   = decode(instr1[31:26], instr1[25:21], instr1[20:16], instr1[5:0]);
                dst0    = dest_reg(ctrl0[2:1], instr0[20:16], instr0[15:11]);
                raw     = ctrl0[0] && (dst0 != 5'd0) &&
                          ((dst0 == instr1[25:21]) ||
                           (reads_rt(instr1[31:26], instr1[25:21]) && (dst0 == instr1[20:16])));
                pair_ok = !(ctrl1[22] || ctrl1[23]) &&
                          !((ctrl0[4] || ctrl0[5]) && (ctrl1[4] || ctrl1[5])) &&
                          !(|ctrl0[20:14]) && !(|ctrl1[20:14]) && !raw;
            end

            assign out_valid = {has1 && (count > CNT_ONE) && pair_ok, has1};
            assign out_instr = {instr1, instr0};
            assign out_pc    = {pc1, pc0};
            assign out_ctrl  = {ctrl1, ctrl0};
            assign pop_n     = out_ready ? ({1'b0, out_valid[1]} + {1'b0, out_valid[0]}) : 2'd0;
        end else begin : g_single
            assign out_valid = has1;
            assign out_instr = instr0;
            assign out_pc    = pc0;
            assign out_ctrl  = ctrl0;
            assign pop_n     = out_ready ? {1'b0, has1} : 2'd0;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_inst_decode_queue.sv
`default_nettype none
// ============================================================================
// tb_inst_decode_queue : directed and randomized checks of inst_decode_queue
// Revision 1.0
// ============================================================================
module tb_inst_decode_queue;
    localparam int DEPTH   = 8;
    localparam int ISSUE_W = 2;
    localparam int NT      = 27;
    localparam logic [23:0] CMP_MASK = 24'hFFF87F;  // aluop encoding is not pinned

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [63:0] in_instr, in_pc;
    logic        in_ready, flush, out_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_instr, out_pc;
    logic [47:0] out_ctrl;
    logic [3:0]  count;

    inst_decode_queue #(.DEPTH(DEPTH), .ISSUE_W(ISSUE_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_ready(in_ready), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .out_instr(out_instr), .out_pc(out_pc), .out_ctrl(out_ctrl), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        int          t;
    } ent_t;

    ent_t        q[$];
    logic [31:0] t_base [NT];
    logic [31:0] t_mask [NT];
    logic [23:0] t_ctrl [NT];
    bit          t_rt   [NT];
    int          n_vec = 0, n_err = 0;
    logic [31:0] pcnt  = 32'h0040_0000;

    logic        p_fl, p_rdy;
    int          p_pop;
    logic [1:0]  p_v;
    ent_t        p_e0, p_e1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic deft(input int i, input logic [31:0] b, input logic [31:0] m,
                        input logic [23:0] c, input bit r);
        t_base[i] = b; t_mask[i] = m; t_ctrl[i] = c; t_rt[i] = r;
    endtask

    task automatic init_tables();
        deft( 0, 32'h0000_0021, 32'h03FF_F800, 24'h000001, 1);  // addu
        deft( 1, 32'h0000_0023, 32'h03FF_F800, 24'h000001, 1);  // subu
        deft( 2, 32'h0000_0000, 32'h03FF_F800, 24'h000001, 1);  // sll
        deft( 3, 32'h0000_0008, 32'h03FF_F800, 24'h400000, 1);  // jr
        deft( 4, 32'h0000_0009, 32'h03FF_F800, 24'h400001, 1);  // jalr
        deft( 5, 32'h0000_0010, 32'h03FF_F800, 24'h100001, 1);  // mfhi
        deft( 6, 32'h0000_0018, 32'h03FF_F800, 24'h000000, 1);  // mult
        deft( 7, 32'h0000_000C, 32'h03FF_F800, 24'h010000, 1);  // syscall
        deft( 8, 32'h0000_000D, 32'h03FF_F800, 24'h008000, 1);  // break
        deft( 9, 32'h0000_003F, 32'h03FF_F800, 24'h004000, 1);  // unknown funct
        deft(10, 32'h2400_0000, 32'h03FF_FFFF, 24'h20000B, 0);  // addiu
        deft(11, 32'h3400_0000, 32'h03FF_FFFF, 24'h00000B, 0);  // ori
        deft(12, 32'h3C00_0000, 32'h03FF_FFFF, 24'h00000B, 0);  // lui
        deft(13, 32'h8C00_0000, 32'h03FF_FFFF, 24'h20005B, 0);  // lw
        deft(14, 32'hAC00_0000, 32'h03FF_FFFF, 24'h200028, 1);  // sw
        deft(15, 32'h1000_0000, 32'h03FF_FFFF, 24'h800800, 1);  // beq
        deft(16, 32'h1400_0000, 32'h03FF_FFFF, 24'h801000, 1);  // bne
        deft(17, 32'h0800_0000, 32'h03FF_FFFF, 24'h400000, 0);  // j
        deft(18, 32'h0C00_0000, 32'h03FF_FFFF, 24'h400005, 0);  // jal
        deft(19, 32'h0411_0000, 32'h03E0_FFFF, 24'h803005, 0);  // bgezal
        deft(20, 32'h0400_0000, 32'h03E0_FFFF, 24'h802800, 0);  // bltz
        deft(21, 32'h0405_0000, 32'h03E0_FFFF, 24'h006800, 0);  // unknown REGIMM rt
        deft(22, 32'h4000_0000, 32'h001F_F800, 24'h080003, 0);  // mfc0
        deft(23, 32'h4080_0000, 32'h001F_F800, 24'h040000, 1);  // mtc0
        deft(24, 32'h4200_0018, 32'h0000_0000, 24'h020000, 0);  // eret
        deft(25, 32'hFC00_0000, 32'h03FF_FFFF, 24'h004000, 0);  // unknown opcode
        deft(26, 32'h4020_0000, 32'h001F_F800, 24'h004000, 0);  // unknown COP0 rs
    endtask

    function automatic logic [31:0] rand_instr(input int t);
        logic [31:0] f;
        f = (32'($urandom_range(0, 3)) << 21) | (32'($urandom_range(0, 3)) << 16) |
            (32'($urandom_range(0, 3)) << 11) | ($urandom & 32'h0000_07FF);
        return t_base[t] | (f & t_mask[t]);
    endfunction

    function automatic bit pairable(input ent_t a, input ent_t b);
        logic [23:0] ca, cb;
        logic [4:0]  d;
        ca = t_ctrl[a.t];
        cb = t_ctrl[b.t];
        if (cb[22] || cb[23]) return 0;
        if ((ca[4] || ca[5]) && (cb[4] || cb[5])) return 0;
        if ((|ca[20:14]) || (|cb[20:14])) return 0;
        d = (ca[2:1] == 2'b00) ? a.instr[15:11] : (ca[2:1] == 2'b01) ? a.instr[20:16] : 5'd31;
        if (ca[0] && d != 5'd0 && (d == b.instr[25:21] || (t_rt[b.t] && d == b.instr[20:16])))
            return 0;
        return 1;
    endfunction

    // Apply inputs just after the edge, then compare against the model mid-cycle.
    task automatic cycle(input logic [1:0] v, input int t0, input logic [31:0] i0,
                         input int t1, input logic [31:0] i1, input logic fl, input logic ordy);
        int   n;
        logic e0, e1;
        in_valid = v; in_instr = {i1, i0}; in_pc = {pcnt + 32'd4, pcnt};
        flush = fl; out_ready = ordy;
        #3;
        n  = q.size();
        e0 = (n >= 1) && !fl;
        e1 = (n >= 2) && !fl && pairable(q[0], q[1]);
        chk("count", 64'(count), 64'(n));
        chk("in_ready", 64'(in_ready), 64'(n <= DEPTH - 2));
        chk("out_valid", 64'(out_valid), 64'({e1, e0}));
        if (e0) begin
            chk("instr0", 64'(out_instr[31:0]), 64'(q[0].instr));
            chk("pc0", 64'(out_pc[31:0]), 64'(q[0].pc));
            chk("ctrl0", 64'(out_ctrl[23:0] & CMP_MASK), 64'(t_ctrl[q[0].t] & CMP_MASK));
        end
        if (e1) begin
            chk("instr1", 64'(out_instr[63:32]), 64'(q[1].instr));
            chk("pc1", 64'(out_pc[63:32]), 64'(q[1].pc));
            chk("ctrl1", 64'(out_ctrl[47:24] & CMP_MASK), 64'(t_ctrl[q[1].t] & CMP_MASK));
        end
        p_fl  = fl;
        p_rdy = (n <= DEPTH - 2);
        p_pop = ordy ? (int'(e0) + int'(e1)) : 0;
        p_v   = v;
        p_e0  = '{i0, pcnt, t0};
        p_e1  = '{i1, pcnt + 32'd4, t1};
    endtask

    task automatic tick();
        if (p_fl) begin
            q.delete();
        end else begin
            for (int k = 0; k < p_pop; k++) void'(q.pop_front());
            if (p_rdy && p_v[0]) q.push_back(p_e0);
            if (p_rdy && p_v[1]) q.push_back(p_e1);
        end
        pcnt = pcnt + 32'd8;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_check(input string tag);
        in_valid = 2'b00; flush = 1'b0; out_ready = 1'b0; rst = 1'b1;
        #3;
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int         r, t0, t1;
        logic [1:0] v;
        init_tables();
        rst = 1'b1; in_valid = 2'b00; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_check("rst");

        // addu $3,$1,$2 ; ori $4,$5,1 pair
        cycle(2'b11, 0, 32'h0022_1821, 11, 32'h34A4_0001, 1'b0, 1'b0); tick();
        cycle(2'b00, 0, 32'h0, 0, 32'h0, 1'b0, 1'b1);
        chk("d1_valid", 64'(out_valid), 64'h3);
        chk("d1_rw0", 64'(out_ctrl[0]), 64'd1);
        chk("d1_rdst0", 64'(out_ctrl[2:1]), 64'd0);
        chk("d1_imm1", 64'(out_ctrl[27]), 64'd1);
        chk("d1_rdst1", 64'(out_ctrl[26:25]), 64'd1);
        chk("d1_count", 64'(count), 64'd2);
        tick();

        // RAW on $3 splits the pair
        cycle(2'b11, 0, 32'h0022_1821, 0, 32'h0064_3021, 1'b0, 1'b0); tick();
        cycle(2'b00, 0, 32'h0, 0, 32'h0, 1'b0, 1'b1);
        chk("d2_valid", 64'(out_valid), 64'h1);
        tick();
        cycle(2'b00, 0, 32'h0, 0, 32'h0, 1'b0, 1'b1);
        chk("d2_valid_b", 64'(out_valid), 64'h1);
        chk("d2_instr", 64'(out_instr[31:0]), 64'h0064_3021);
        tick();

        // beq with its delay slot
        cycle(2'b11, 15, 32'h1022_0004, 2, 32'h0, 1'b0, 1'b0); tick();
        cycle(2'b00, 0, 32'h0, 0, 32'h0, 1'b0, 1'b1);
        chk("d3_valid", 64'(out_valid), 64'h3);
        chk("d3_bj", 64'(out_ctrl[13:11]), 64'h1);
        chk("d3_isbr", 64'(out_ctrl[23]), 64'd1);
        tick();

        // fill to DEPTH-1, dropped push, then flush with push and pop
        for (int k = 0; k < 3; k++) begin
            cycle(2'b11, 2, 32'h0, 2, 32'h0, 1'b0, 1'b0); tick();
        end
        cycle(2'b01, 2, 32'h0, 2, 32'h0, 1'b0, 1'b0); tick();
        cycle(2'b11, 0, 32'h0022_1821, 0, 32'h0022_1821, 1'b0, 1'b0);
        chk("d4_count", 64'(count), 64'(DEPTH - 1));
        chk("d4_ready", 64'(in_ready), 64'd0);
        tick();
        cycle(2'b00, 0, 32'h0, 0, 32'h0, 1'b0, 1'b1);
        chk("d4_count_b", 64'(count), 64'(DEPTH - 1));
        tick();
        cycle(2'b11, 0, 32'h0022_1821, 0, 32'h0022_1821, 1'b1, 1'b1);
        chk("d5_count", 64'(count), 64'd5);
        chk("d5_valid", 64'(out_valid), 64'h0);
        tick();
        cycle(2'b00, 0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        chk("d5_count_b", 64'(count), 64'd0);
        tick();

        // reserved encodings
        cycle(2'b11, 25, 32'hFC00_0000, 21, 32'h0405_0000, 1'b0, 1'b0); tick();
        cycle(2'b00, 0, 32'h0, 0, 32'h0, 1'b0, 1'b1);
        chk("d6_valid", 64'(out_valid), 64'h1);
        chk("d6_ri", 64'(out_ctrl[14]), 64'd1);
        chk("d6_rw", 64'(out_ctrl[0]), 64'd0);
        chk("d6_mw", 64'(out_ctrl[5]), 64'd0);
        tick();
        cycle(2'b00, 0, 32'h0, 0, 32'h0, 1'b0, 1'b1);
        chk("d7_ri", 64'(out_ctrl[14]), 64'd1);
        chk("d7_bj", 64'(out_ctrl[13:11]), 64'h5);
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) reset_check("mid_rst");
            r  = $urandom_range(0, 2);
            v  = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            t0 = ($urandom_range(0, 1) == 0) ? $urandom_range(0, NT - 1) : $urandom_range(10, 14);
            t1 = ($urandom_range(0, 1) == 0) ? $urandom_range(0, NT - 1) : $urandom_range(0, 2);
            cycle(v, t0, rand_instr(t0), t1, rand_instr(t1),
                  ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 55));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
